// File: rtl/pixel_readout.sv
// Pixel array readout sequencer: scans pixel_count pixels, Gray-decodes each sample and
// presents it on a valid/ready output port.
module pixel_readout #(
  parameter int unsigned pixel_count   = 4,
  parameter int unsigned counter_width = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  output logic                           read,
  output logic [$clog2(pixel_count)-1:0] pixel_select,
  input  logic [counter_width-1:0]       data_in,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [counter_width-1:0]       out_data,
  output logic [$clog2(pixel_count)-1:0] out_index,
  output logic                           out_last,
  output logic                           busy,
  output logic                           done
);

  localparam int unsigned IdxW = $clog2(pixel_count);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(pixel_count - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSelect,
    StSample,
    StOutput,
    StDone
  } state_e;

  state_e                   state_q, state_d;
  logic [IdxW-1:0]          index_q, index_d;
  logic [counter_width-1:0] data_q, data_d;
  logic [counter_width-1:0] gray_bin;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    gray_bin = '0;
    for (int i = 0; i < int'(counter_width); i++) begin
      gray_bin[i] = ^(data_in >> i);
    end
  end

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    data_d  = data_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          index_d = '0;
          state_d = StSelect;
        end
      end
      StSelect: state_d = StSample;
      StSample: begin
        data_d  = gray_bin;
        state_d = StOutput;
      end
      StOutput: begin
        if (out_ready) begin
          if (index_q == LastIdx) begin
            state_d = StDone;
          end else begin
            index_d = index_q + 1'b1;
            state_d = StSelect;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      index_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      index_q <= index_d;
      data_q  <= data_d;
    end
  end

  // All outputs decode from registered state, so out_valid never sees out_ready.
  always_comb begin
    read         = (state_q == StSelect) || (state_q == StSample);
    pixel_select = index_q;
    out_valid    = (state_q == StOutput);
    out_data     = data_q;
    out_index    = index_q;
    out_last     = (state_q == StOutput) && (index_q == LastIdx);
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
  end

endmodule

// File: tb/tb_pixel_readout.sv
// Self-checking bench for pixel_readout: scoreboard of expected words, a 4-pixel and a
// 3-pixel instance.
module tb_pixel_readout;

  typedef struct {
    logic [7:0] data;
    logic [1:0] index;
    logic       last;
  } exp_t;

  logic       clk, reset, start, out_ready;
  logic       read, out_valid, out_last, busy, done;
  logic [1:0] pixel_select, out_index;
  logic [7:0] data_in, out_data;

  logic       start3, out_ready3;
  logic       read3, out_valid3, out_last3, busy3, done3;
  logic [1:0] pixel_select3, out_index3;
  logic [7:0] data_in3, out_data3;

  logic [7:0] pix_mem [4];
  exp_t       exp_q[$];
  exp_t       exp3[$];
  exp_t       mon_e;
  logic [7:0] got[$];

  int checks = 0;
  int errors = 0;
  int words  = 0;
  int dones  = 0;
  int first_valid, done_at;
  logic [1:0] first_idx;

  assign data_in  = pix_mem[pixel_select];
  assign data_in3 = pix_mem[pixel_select3];

  pixel_readout #(.pixel_count(4), .counter_width(8)) dut (
    .clk(clk), .reset(reset), .start(start), .read(read), .pixel_select(pixel_select),
    .data_in(data_in), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_index(out_index), .out_last(out_last), .busy(busy), .done(done)
  );

  pixel_readout #(.pixel_count(3), .counter_width(8)) dut3 (
    .clk(clk), .reset(reset), .start(start3), .read(read3), .pixel_select(pixel_select3),
    .data_in(data_in3), .out_valid(out_valid3), .out_ready(out_ready3), .out_data(out_data3),
    .out_index(out_index3), .out_last(out_last3), .busy(busy3), .done(done3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] gray2bin(input logic [7:0] g);
    logic [7:0] b;
    b[7] = g[7];
    for (int i = 6; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  task automatic push_frame();
    exp_t e;
    for (int p = 0; p < 4; p++) begin
      e.data  = gray2bin(pix_mem[p]);
      e.index = 2'(p);
      e.last  = (p == 3);
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard monitor for the 4-pixel instance.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      checks++;
      if (read && out_valid) begin
        errors++;
        $display("FAIL read_valid_excl read=%b out_valid=%b required not both 1", read, out_valid);
      end
      if (out_valid && out_ready) begin
        words++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_word idx=%0d data=%h required no word", out_index, out_data);
        end else begin
          mon_e = exp_q.pop_front();
          if ({out_data, out_index, out_last} !== {mon_e.data, mon_e.index, mon_e.last}) begin
            errors++;
            $display("FAIL word data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                     out_data, out_index, out_last, mon_e.data, mon_e.index, mon_e.last);
          end
        end
      end
      if (done) dones++;
    end
  end

  // Pulses start and records timing relative to the cycle start was raised in.
  task automatic run_frame();
    first_valid = -1;
    done_at     = -1;
    first_idx   = 2'bxx;
    got.delete();
    @(posedge clk); #1 start = 1'b1;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (out_valid && first_valid < 0) begin
        first_valid = n;
        first_idx   = out_index;
      end
      if (done && done_at < 0) done_at = n;
      if (out_valid && out_ready) got.push_back(out_data);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #2 reset = 1'b0;
    #6;
    checks++;
    if ({read, pixel_select, out_valid, out_data, out_index, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got=%b required all zero",
               {read, pixel_select, out_valid, out_data, out_index, out_last, busy, done});
    end
    checks++;
    if ({read3, pixel_select3, out_valid3, busy3, done3} !== '0) begin
      errors++;
      $display("FAIL reset_outputs3 got=%b required all zero",
               {read3, pixel_select3, out_valid3, busy3, done3});
    end
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_zero_frame();
    for (int p = 0; p < 4; p++) pix_mem[p] = 8'h00;
    words = 0; dones = 0;
    push_frame();
    run_frame();
    checks++;
    if (first_valid != 3) begin
      errors++;
      $display("FAIL start_to_valid got=%0d required=3", first_valid);
    end
    checks++;
    if (done_at != 13) begin
      errors++;
      $display("FAIL start_to_done got=%0d required=13", done_at);
    end
    checks++;
    if (words != 4 || dones != 1) begin
      errors++;
      $display("FAIL zero_counts words=%0d dones=%0d required 4 and 1", words, dones);
    end
  endtask

  task automatic test_gray();
    logic [7:0] want [4];
    want = '{8'h1D, 8'hFF, 8'h80, 8'h01};
    pix_mem = '{8'h13, 8'h80, 8'hC0, 8'h01};
    words = 0; dones = 0;
    push_frame();
    run_frame();
    checks++;
    if (got.size() != 4) begin
      errors++;
      $display("FAIL gray_count got=%0d required=4", got.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < got.size()) begin
        checks++;
        if (got[k] !== want[k]) begin
          errors++;
          $display("FAIL gray_word%0d got=%h required=%h", k, got[k], want[k]);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    bit found = 0;
    bit saw_done = 0;
    logic [7:0] hold;
    pix_mem = '{8'h5A, 8'hA5, 8'h3C, 8'hFF};
    hold = gray2bin(8'hA5);
    words = 0; dones = 0;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (out_valid && out_index == 2'd1) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stall_reach found=0 required=1");
    end
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || read !== 1'b0 || out_data !== hold || out_index !== 2'd1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d valid=%b read=%b data=%h idx=%0d required 1 0 %h 1",
                 k, out_valid, read, out_data, out_index, hold);
      end
    end
    @(posedge clk); #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (read !== 1'b1 || pixel_select !== 2'd2 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL resume read=%b sel=%0d valid=%b required 1 2 0", read, pixel_select,
               out_valid);
    end
    for (int k = 0; k < 20 && !saw_done; k++) begin
      @(negedge clk);
      if (done) saw_done = 1;
    end
    @(negedge clk);
    checks++;
    if (words != 4 || dones != 1 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_counts words=%0d dones=%0d left=%0d required 4 1 0", words, dones,
               exp_q.size());
    end
  endtask

  task automatic test_start_ignored();
    pix_mem = '{8'h01, 8'h02, 8'h04, 8'h08};
    words = 0; dones = 0;
    push_frame();
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      start = (c == 0) || (busy && !done && (c % 2 == 1));
    end
    start = 1'b0;
    @(negedge clk);
    checks++;
    if (words != 4 || dones != 1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL restart_ignored words=%0d dones=%0d busy=%b required 4 1 0", words, dones,
               busy);
    end
  endtask

  task automatic test_async_reset();
    bit found = 0;
    pix_mem = '{8'h11, 8'h22, 8'h33, 8'h44};
    words = 0; dones = 0;
    push_frame();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      if (read && pixel_select == 2'd2) found = 1;
      else begin
        @(posedge clk); #1;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_reach found=0 required=1");
    end
    @(posedge clk); #1;
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({read, pixel_select, out_valid, out_data, out_index, out_last, busy, done} !== '0) begin
      errors++;
      $display("FAIL async_reset got=%b required all zero",
               {read, pixel_select, out_valid, out_data, out_index, out_last, busy, done});
    end
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    words = 0; dones = 0;
    repeat (6) @(negedge clk);
    checks++;
    if (words != 0 || dones != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after_reset_idle words=%0d dones=%0d busy=%b required 0 0 0", words, dones,
               busy);
    end
    push_frame();
    run_frame();
    checks++;
    if (first_idx !== 2'd0 || words != 4 || dones != 1) begin
      errors++;
      $display("FAIL restart_frame idx=%0d words=%0d dones=%0d required 0 4 1", first_idx, words,
               dones);
    end
  endtask

  task automatic test_three_pixels();
    exp_t e;
    int   cnt = 0;
    int   d3  = 0;
    pix_mem = '{8'h0F, 8'hF0, 8'h77, 8'hEE};
    for (int p = 0; p < 3; p++) begin
      e.data  = gray2bin(pix_mem[p]);
      e.index = 2'(p);
      e.last  = (p == 2);
      exp3.push_back(e);
    end
    @(posedge clk); #1 start3 = 1'b1;
    for (int n = 0; n < 25; n++) begin
      @(negedge clk);
      if (n == 1) start3 = 1'b0;
      checks++;
      if (pixel_select3 > 2'd2) begin
        errors++;
        $display("FAIL sel3_range got=%0d required<=2", pixel_select3);
      end
      if (out_valid3) begin
        cnt++;
        checks++;
        if (exp3.size() == 0) begin
          errors++;
          $display("FAIL word3_extra idx=%0d required no word", out_index3);
        end else begin
          e = exp3.pop_front();
          if ({out_data3, out_index3, out_last3} !== {e.data, e.index, e.last}) begin
            errors++;
            $display("FAIL word3 data=%h idx=%0d last=%b required data=%h idx=%0d last=%b",
                     out_data3, out_index3, out_last3, e.data, e.index, e.last);
          end
        end
      end
      if (done3) d3++;
    end
    checks++;
    if (cnt != 3 || d3 != 1) begin
      errors++;
      $display("FAIL three_counts words=%0d dones=%0d required 3 1", cnt, d3);
    end
  endtask

  initial begin
    start      = 1'b0;
    start3     = 1'b0;
    out_ready  = 1'b1;
    out_ready3 = 1'b1;
    pix_mem    = '{8'h00, 8'h00, 8'h00, 8'h00};
    test_reset();
    test_zero_frame();
    test_gray();
    test_backpressure();
    test_start_ignored();
    test_async_reset();
    test_three_pixels();
    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_readout.md
PIXEL_READOUT -- requirements
Module: pixel_readout

Interface
REQ-001 SHALL have parameter pixel_count, default 4: number of pixels scanned per frame, at least 2.
REQ-002 SHALL have parameter counter_width, default 8: width of the Gray-coded pixel data bus.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (reset=0 resets).
REQ-005 SHALL have port start  input  1  frame readout request, sampled only in IDLE.
REQ-006 SHALL have port read  output  1  drives the pixel array read enable.
REQ-007 SHALL have port pixel_select  output  $clog2(pixel_count)  index of the pixel being read.
REQ-008 SHALL have port data_in  input  counter_width  Gray-coded value driven by the selected pixel.
REQ-009 SHALL have port out_valid  output  1  out_data/out_index/out_last valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts the current word.
REQ-011 SHALL have port out_data  output  counter_width  binary-decoded pixel value.
REQ-012 SHALL have port out_index  output  $clog2(pixel_count)  pixel index of out_data.
REQ-013 SHALL have port out_last  output  1  high with out_valid for index pixel_count-1.
REQ-014 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-015 SHALL have port done  output  1  one-cycle pulse at frame completion.

Function
REQ-016 SHALL implement the FSM states IDLE, SELECT, SAMPLE, OUTPUT and DONE.
REQ-017 IDLE: SHALL go to SELECT when start=1, clearing the pixel index to 0; SHALL remain in IDLE otherwise.
REQ-018 SELECT: read=1 and pixel_select=index; SHALL go to SAMPLE unconditionally. This is a one-cycle settle for the array's tri-state bus.
REQ-019 SAMPLE: read=1; SHALL register data_in at the exiting edge, Gray-decode it and go to OUTPUT.
REQ-020 Gray decode SHALL be b[MSB]=g[MSB] and b[i]=b[i+1] XOR g[i], down to bit 0.
REQ-021 OUTPUT: read=0 and out_valid=1; out_data, out_index and out_last SHALL be held stable until out_valid and out_ready are both 1 at an edge.
REQ-022 On the OUTPUT handshake, if index<pixel_count-1 the FSM SHALL increment the index and go to SELECT; otherwise it SHALL go to DONE.
REQ-023 DONE: done=1 for exactly one cycle, then the FSM SHALL go to IDLE.
REQ-024 start SHALL be ignored outside IDLE and SHALL NOT be queued.
REQ-025 Timing: the start edge to out_valid=1 SHALL be 3 cycles. With out_ready held at 1, pixels SHALL repeat every 3 cycles and done SHALL occur 1 cycle after the last handshake.
REQ-026 out_valid SHALL NOT depend combinationally on out_ready. Backpressure of any length SHALL stall only in OUTPUT, with read=0.
REQ-027 The pixel index SHALL NOT exceed pixel_count-1, including for non-power-of-2 pixel_count.
REQ-028 read and out_valid SHALL never be 1 in the same cycle.

Reset
REQ-029 While reset=0, the block SHALL immediately (asynchronously) enter IDLE with read=0, pixel_select=0, out_valid=0, out_data=0, out_index=0, out_last=0, busy=0 and done=0.
REQ-030 A reset mid-frame SHALL abandon the frame, and no further outputs SHALL be produced until a new start after reset=1.

Verification
REQ-031 With data_in fixed at 8'h00, start pulse and out_ready=1, the bench SHALL see 4 words out_data=0 at indices 0..3, out_last only at index 3, and done 13 cycles after start.
REQ-032 With data_in=8'h13 for pixel 0, 8'h80 for pixel 1, 8'hC0 for pixel 2 and 8'h01 for pixel 3, the bench SHALL see out_data 8'h1D, 8'hFF, 8'h80 and 8'h01.
REQ-033 With out_ready=0 for 10 cycles at index 1, the bench SHALL see out_valid held, out_data/out_index stable, read=0, and resumption on the cycle after out_ready=1.
REQ-034 With start re-pulsed while busy, the bench SHALL see no effect: exactly 4 words and 1 done pulse.
REQ-035 With reset=0 asserted asynchronously during SAMPLE of index 2, the bench SHALL see all outputs zero before the next edge, and a new start SHALL read from index 0.
REQ-036 With pixel_count=3, the bench SHALL see indices 0,1,2 only, out_last at index 2, and pixel_select never equal to 3.
